pwm_fade_sched: RTL and testbench
=================================

// Module: pwm_fade_sched
// PURPOSE
//   Shares one pwm instance (4-bit duty_cycle) between N_REQ animation requesters.
//   Round-robin arbitration selects one requester. The block ramps duty_cycle one LSB
//   per STEP_CYCLES toward that requester's target, holds it for HOLD_CYCLES, then
//   releases. It sits between the LED-animation requesters and the pwm datapath,
//   replacing a fixed per-pattern duty sequencer.
// PARAMETERS
//   N_REQ        4    number of requesters (>=2)
//   DW           4    duty_cycle width; must match pwm
//   STEP_CYCLES  16   clk cycles per 1-LSB duty step (>=1)
//   HOLD_CYCLES  32   clk cycles duty is held at target before release (>=1)
// PORTS
//   clk         in   1          single clock, all logic on rising edge
//   rst         in   1          synchronous, active-high reset
//   req         in   N_REQ      per-requester level request; hold high until done
//   tgt_duty    in   N_REQ*DW   target duty; slice i = tgt_duty[i*DW +: DW]
//   gnt         out  N_REQ      one-hot ownership, registered
//   done        out  N_REQ      1-cycle pulse on the owner's bit at normal completion
//   duty_cycle  out  DW         drives pwm.duty_cycle
//   ready       out  1          high when IDLE (no owner)
// BEHAVIOUR
//   Reset: state=IDLE, duty_cycle=0, gnt=0, done=0, ready=1, rr_ptr=0, counters=0.
//     Reset mid-operation aborts immediately. No done pulse. duty_cycle returns to 0.
//   States:
//     IDLE -> RAMP  : any req. Winner = first set req[] at or after rr_ptr, wrapping
//                     modulo N_REQ. On that edge, latch tgt = winner's tgt_duty slice,
//                     set gnt=onehot(winner), ready=0. Latency req->gnt is 1 cycle.
//     RAMP          : if duty_cycle==tgt -> HOLD and clear cnt. Else cnt++.
//                     When cnt==STEP_CYCLES-1: cnt<=0; duty_cycle moves +/-1 toward tgt.
//                     duty never overshoots tgt and never wraps (0..2^DW-1).
//     HOLD          : cnt++. When cnt==HOLD_CYCLES-1: done[owner]<=1 for one cycle,
//                     gnt<=0, rr_ptr<=(owner+1)%N_REQ, state IDLE, ready<=1.
//   Timing, grant edge G, start duty d, target t:
//     - duty reaches t at G+|t-d|*STEP_CYCLES
//     - HOLD entered at G+|t-d|*STEP_CYCLES+1
//     - done/gnt-drop at G+|t-d|*STEP_CYCLES+1+HOLD_CYCLES
//     - t==d: HOLD entered at G+1
//   Other rules:
//     - duty_cycle is retained across release and IDLE; the next owner ramps from the
//       current level, not from 0.
//     - tgt_duty is sampled only on the grant edge; later changes are ignored.
//   Withdrawal: owner's req low in RAMP or HOLD -> next edge gnt=0, no done pulse,
//     duty held, rr_ptr advances past owner, state IDLE.
//   Contention: requests from non-owners wait (no preemption). A req arriving on the
//     same edge as release is arbitrated from IDLE on the following edge (1 idle cycle
//     minimum between owners).
//   Invariants: at most one gnt bit and at most one done bit set per cycle;
//     ready == (gnt==0).
// TESTING  (bench uses STEP_CYCLES=4, HOLD_CYCLES=8, N_REQ=4)
//   1. Reset, then req=0001, tgt0=3 at G-1 -> gnt=0001 at G; duty 1/2/3 at G+4/8/12;
//      done=0001 one cycle at G+21; ready=1 at G+21.
//   2. After test 1 (duty=3), req=0010, tgt1=1 -> duty ramps down 2 then 1 (step every
//      4 cycles), done[1] at G+17; duty stays 1 afterwards.
//   3. req=1111 continuously, all tgt equal to current duty -> grants in order 0,1,2,3,0,
//      each lasting 1+8 cycles, one idle cycle between; never two gnt bits set.
//   4. Owner drops req mid-RAMP (duty=2 of target 5) -> gnt=0 next edge, done stays 0,
//      duty holds 2, next pending requester granted one cycle later.
//   5. rst during HOLD with duty=7 -> next edge: duty=0, gnt=0, done=0, ready=1,
//      rr_ptr=0.
//   6. tgt0=15 from duty=0 -> duty saturates at 15 without wrap; tgt changed to 0 after
//      grant has no effect.

Source files
------------

// File: rtl/pwm_fade_sched_if.sv
// Bus between the LED-animation requesters and the shared pwm duty-cycle fade scheduler.
interface pwm_fade_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] tgt_duty;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic [DW-1:0]       duty_cycle;
  logic                ready;

  modport master (
    output req, tgt_duty,
    input  gnt, done, duty_cycle, ready
  );

  modport slave (
    input  req, tgt_duty,
    output gnt, done, duty_cycle, ready
  );
endinterface

// File: rtl/pwm_fade_sched.sv
// Round-robin shares one pwm duty_cycle among N_REQ requesters: ramp toward the
// owner's target one LSB per STEP_CYCLES, hold HOLD_CYCLES, then release.
module pwm_fade_sched #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DW          = 4,
  parameter int unsigned STEP_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  pwm_fade_sched_if.slave bus
);
  localparam int unsigned IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CMAX = (STEP_CYCLES > HOLD_CYCLES) ? STEP_CYCLES : HOLD_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     duty_q, duty_d;
  logic [DW-1:0]     tgt_q, tgt_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              ready_q, ready_d;

  logic [DW-1:0]     tgt_arr_c [N_REQ];
  logic              arb_valid_c;
  logic [IW-1:0]     arb_idx_c;

  // (base + off) mod N_REQ for off < N_REQ
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      tgt_arr_c[i] = bus.tgt_duty[i*DW +: DW];
    end
  end

  // First requester at or after rr_ptr, wrapping
  always_comb begin
    arb_valid_c = 1'b0;
    arb_idx_c   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!arb_valid_c && bus.req[wrap_add(rr_ptr_q, k)]) begin
        arb_valid_c = 1'b1;
        arb_idx_c   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    tgt_d    = tgt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    ready_d  = ready_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid_c) begin
          state_d = RAMP;
          cnt_d   = '0;
          tgt_d   = tgt_arr_c[arb_idx_c];
          owner_d = arb_idx_c;
          gnt_d   = ONE_HOT0 << arb_idx_c;
          ready_d = 1'b0;
        end
      end
      RAMP: begin
        if (!bus.req[owner_q]) begin
          state_d  = IDLE;
          cnt_d    = '0;
          gnt_d    = '0;
          ready_d  = 1'b1;
          rr_ptr_d = wrap_add(owner_q, 1);
        end else if (duty_q == tgt_q) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CW'(STEP_CYCLES - 1)) begin
          cnt_d  = '0;
          duty_d = (duty_q < tgt_q) ? duty_q + 1'b1 : duty_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!bus.req[owner_q]) begin
          state_d  = IDLE;
          cnt_d    = '0;
          gnt_d    = '0;
          ready_d  = 1'b1;
          rr_ptr_d = wrap_add(owner_q, 1);
        end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d  = IDLE;
          cnt_d    = '0;
          done_d   = gnt_q;
          gnt_d    = '0;
          ready_d  = 1'b1;
          rr_ptr_d = wrap_add(owner_q, 1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      duty_q   <= '0;
      tgt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      tgt_q    <= tgt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.duty_cycle = duty_q;
  assign bus.ready      = ready_q;

endmodule

// File: tb/tb_pwm_fade_sched.sv
// Directed bench for pwm_fade_sched with STEP_CYCLES=4, HOLD_CYCLES=8, N_REQ=4.
module tb_pwm_fade_sched;
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DW     = 4;
  localparam int unsigned STEP_C = 4;
  localparam int unsigned HOLD_C = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  pwm_fade_sched_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  pwm_fade_sched #(
    .N_REQ(N_REQ), .DW(DW), .STEP_CYCLES(STEP_C), .HOLD_CYCLES(HOLD_C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  initial begin
    rst          = 1'b1;
    bus.req      = '0;
    bus.tgt_duty = '0;
    tick();
    tick();
    chk("rst_duty",  int'(bus.duty_cycle), 0);
    chk("rst_gnt",   int'(bus.gnt), 0);
    chk("rst_done",  int'(bus.done), 0);
    chk("rst_ready", int'(bus.ready), 1);

    // Ramp up 0 -> 3 for requester 0
    rst          = 1'b0;
    bus.req      = 4'b0001;
    bus.tgt_duty = 16'h0003;
    tick();
    chk("t1_gnt",   int'(bus.gnt), 1);
    chk("t1_ready", int'(bus.ready), 0);
    chk("t1_duty0", int'(bus.duty_cycle), 0);
    for (int c = 1; c <= 21; c++) begin
      tick();
      chk("t1_duty", int'(bus.duty_cycle), imin(c / 4, 3));
      chk("t1_done", int'(bus.done), (c == 21) ? 1 : 0);
    end
    chk("t1_gnt_drop", int'(bus.gnt), 0);
    chk("t1_ready_end", int'(bus.ready), 1);
    bus.req = '0;
    tick();
    chk("t1_done_pulse", int'(bus.done), 0);
    chk("t1_idle_gnt", int'(bus.gnt), 0);

    // Ramp down 3 -> 1 for requester 1
    bus.req      = 4'b0010;
    bus.tgt_duty = 16'h0010;
    tick();
    chk("t2_gnt", int'(bus.gnt), 2);
    for (int c = 1; c <= 17; c++) begin
      tick();
      chk("t2_duty", int'(bus.duty_cycle), 3 - imin(c / 4, 2));
      chk("t2_done", int'(bus.done), (c == 17) ? 2 : 0);
    end
    bus.req = '0;
    tick();
    chk("t2_duty_kept", int'(bus.duty_cycle), 1);
    chk("t2_done_clr", int'(bus.done), 0);
    chk("t2_ready", int'(bus.ready), 1);

    // All four requesting with target == current duty: round-robin 0,1,2,3,0
    rst          = 1'b1;
    bus.tgt_duty = '0;
    tick();
    chk("t3_rst_duty", int'(bus.duty_cycle), 0);
    rst     = 1'b0;
    bus.req = 4'b1111;
    tick();
    for (int c = 0; c < 50; c++) begin
      int k;
      int ph;
      if (c > 0) tick();
      k  = (c / 10) % 4;
      ph = c % 10;
      chk("t3_gnt",   int'(bus.gnt),   (ph <= 8) ? (1 << k) : 0);
      chk("t3_done",  int'(bus.done),  (ph == 9) ? (1 << k) : 0);
      chk("t3_ready", int'(bus.ready), (ph == 9) ? 1 : 0);
    end
    bus.req = '0;
    tick();

    // Owner 1 withdraws mid-ramp at duty 2 (target 5); requester 2 waits
    bus.req      = 4'b0110;
    bus.tgt_duty = 16'h0250;
    tick();
    chk("t4_gnt", int'(bus.gnt), 2);
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("t4_duty", int'(bus.duty_cycle), c / 4);
    end
    bus.req = 4'b0100;
    tick();
    chk("t4_gnt_drop", int'(bus.gnt), 0);
    chk("t4_no_done", int'(bus.done), 0);
    chk("t4_duty_held", int'(bus.duty_cycle), 2);
    chk("t4_ready", int'(bus.ready), 1);
    tick();
    chk("t4_next_gnt", int'(bus.gnt), 4);
    chk("t4_next_duty", int'(bus.duty_cycle), 2);
    for (int c = 12; c <= 20; c++) begin
      tick();
      chk("t4_done", int'(bus.done), (c == 20) ? 4 : 0);
      chk("t4_duty2", int'(bus.duty_cycle), 2);
    end
    bus.req = '0;
    tick();

    // Reset while holding duty 7
    bus.req      = 4'b1000;
    bus.tgt_duty = 16'h7000;
    tick();
    chk("t5_gnt", int'(bus.gnt), 8);
    for (int c = 1; c <= 24; c++) begin
      tick();
      chk("t5_duty", int'(bus.duty_cycle), 2 + imin(c / 4, 5));
    end
    rst = 1'b1;
    tick();
    chk("t5_rst_duty",  int'(bus.duty_cycle), 0);
    chk("t5_rst_gnt",   int'(bus.gnt), 0);
    chk("t5_rst_done",  int'(bus.done), 0);
    chk("t5_rst_ready", int'(bus.ready), 1);
    rst          = 1'b0;
    bus.req      = 4'b1010;
    bus.tgt_duty = '0;
    tick();
    chk("t5_rr_ptr0", int'(bus.gnt), 2);
    bus.req = '0;
    tick();
    chk("t5_wd_gnt", int'(bus.gnt), 0);
    chk("t5_wd_done", int'(bus.done), 0);

    // Full-scale ramp to 15; target change after grant is ignored
    bus.req      = 4'b0001;
    bus.tgt_duty = 16'h000F;
    tick();
    chk("t6_gnt", int'(bus.gnt), 1);
    bus.tgt_duty = '0;
    for (int c = 1; c <= 69; c++) begin
      tick();
      chk("t6_duty", int'(bus.duty_cycle), imin(c / 4, 15));
      chk("t6_done", int'(bus.done), (c == 69) ? 1 : 0);
    end
    bus.req = '0;
    tick();
    chk("t6_duty_end", int'(bus.duty_cycle), 15);
    chk("t6_ready", int'(bus.ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
